// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths, NOP encoding, fetch FSM states
// and the instruction field ranges that IF and ID both slice.
package pipeline_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_HOLD = 2'b01,
        S_DROP = 2'b10
    } fetchState_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: a bubble squashes to a NOP, a load captures a new
// instruction, and otherwise the contents hold (stall).
module if_id_reg #(
    parameter int PC_WIDTH    = pipeline_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = pipeline_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   bubble,
    input  logic [INSTR_WIDTH-1:0] nextInstr,
    input  logic [PC_WIDTH-1:0]    nextPc4,
    output logic                   valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc4
);
    import pipeline_pkg::*;

    // Pipeline register update; bubble wins over load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= INSTR_WIDTH'(NOP_INSTR);
            pc4   <= '0;
        end else if (bubble) begin
            valid <= 1'b0;
            instr <= INSTR_WIDTH'(NOP_INSTR);
        end else if (load) begin
            valid <= 1'b1;
            instr <= nextInstr;
            pc4   <= nextPc4;
        end else begin
            valid <= valid;
            instr <= instr;
            pc4   <= pc4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack FSM with stall buffering and redirect
// squashing, feeding the IF/ID register.
module fetch_stage #(
    parameter int                   PC_WIDTH    = pipeline_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = 32'h0000_0000,
    parameter int                   INSTR_WIDTH = pipeline_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   if_id_valid,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc4,
    output logic [5:0]             if_id_opcode,
    output logic [5:0]             if_id_funct
);
    import pipeline_pkg::*;

    fetchState_t            stateReg, nextState;
    logic [PC_WIDTH-1:0]    pcReg, pcNext, pcPlus4, addrReg, addrNext;
    logic [INSTR_WIDTH-1:0] holdReg, holdNext, loadInstr;
    logic                   reqReg, reqNext, ackSeen, ifLoad, ifBubble;

    // An ack only counts while a request is actually on the bus
    assign ackSeen = imem_ack & reqReg;
    assign pcPlus4 = pcReg + PC_WIDTH'(4);

    // FSM, PC, hold buffer and registered imem request/address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= S_REQ;
            pcReg    <= RESET_PC;
            addrReg  <= RESET_PC;
            holdReg  <= INSTR_WIDTH'(NOP_INSTR);
            reqReg   <= 1'b0;
        end else begin
            stateReg <= nextState;
            pcReg    <= pcNext;
            addrReg  <= addrNext;
            holdReg  <= holdNext;
            reqReg   <= reqNext;
        end
    end

    // Next-state, PC and IF/ID control; redirect overrides stall everywhere
    always_comb begin
        nextState = stateReg;
        pcNext    = pcReg;
        holdNext  = holdReg;
        loadInstr = imem_rdata;
        ifLoad    = 1'b0;
        ifBubble  = 1'b0;
        if (redirect_valid) begin
            pcNext   = {redirect_pc[PC_WIDTH-1:2], 2'b00};
            holdNext = INSTR_WIDTH'(NOP_INSTR);
            ifBubble = 1'b1;
            case (stateReg)
                S_REQ:   nextState = (ackSeen || !reqReg) ? S_REQ : S_DROP;
                S_HOLD:  nextState = S_REQ;
                S_DROP:  nextState = ackSeen ? S_REQ : S_DROP;
                default: nextState = S_REQ;
            endcase
        end else begin
            case (stateReg)
                S_REQ: begin
                    if (ackSeen && !stall) begin
                        ifLoad = 1'b1;
                        pcNext = pcPlus4;
                    end else if (ackSeen) begin
                        holdNext  = imem_rdata;
                        nextState = S_HOLD;
                    end else if (!stall) begin
                        ifBubble = 1'b1;
                    end else begin
                        nextState = S_REQ;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        loadInstr = holdReg;
                        ifLoad    = 1'b1;
                        pcNext    = pcPlus4;
                        nextState = S_REQ;
                    end else begin
                        nextState = S_HOLD;
                    end
                end
                S_DROP: begin
                    if (ackSeen) begin
                        nextState = S_REQ;
                    end else begin
                        nextState = S_DROP;
                    end
                end
                default: nextState = S_REQ;
            endcase
        end
        reqNext  = (nextState != S_HOLD);
        // The abandoned address stays on the bus until its ack is absorbed
        addrNext = (nextState == S_DROP) ? addrReg : pcNext;
    end

    assign imem_req  = reqReg;
    assign imem_addr = addrReg;

    if_id_reg #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) uIfId (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ifLoad),
        .bubble    (ifBubble),
        .nextInstr (loadInstr),
        .nextPc4   (pcPlus4),
        .valid     (if_id_valid),
        .instr     (if_id_instr),
        .pc4       (if_id_pc4)
    );

    assign if_id_opcode = if_id_instr[OPCODE_MSB:OPCODE_LSB];
    assign if_id_funct  = if_id_instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, and a
// randomized run against a behavioural fetch model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, redirect_valid = 1'b0, imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0, redirect_pc = 32'h0;
    logic        imem_req, if_id_valid;
    logic [31:0] imem_addr, if_id_instr, if_id_pc4;
    logic [5:0]  if_id_opcode, if_id_funct;
    logic        imem_req2, if_id_valid2;
    logic [31:0] imem_addr2, if_id_instr2, if_id_pc42;
    logic [5:0]  if_id_opcode2, if_id_funct2;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_opcode(if_id_opcode), .if_id_funct(if_id_funct)
    );

    // Same stimulus, reset vector at the top of the address space
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid2), .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc42),
        .if_id_opcode(if_id_opcode2), .if_id_funct(if_id_funct2)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    typedef struct {
        bit          st;
        bit          ack;
        logic [31:0] rd;
        bit          rv;
        logic [31:0] rp;
        bit          ev;
        logic [31:0] ei;
        logic [31:0] ep;
        bit          er;
        logic [31:0] ea;
    } vec_t;

    function automatic vec_t mk(bit st, bit ack, logic [31:0] rd, bit rv, logic [31:0] rp,
                                bit ev, logic [31:0] ei, logic [31:0] ep, bit er, logic [31:0] ea);
        vec_t v;
        v.st = st; v.ack = ack; v.rd = rd; v.rv = rv; v.rp = rp;
        v.ev = ev; v.ei = ei; v.ep = ep; v.er = er; v.ea = ea;
        return v;
    endfunction

    // Behavioural model: where fetching is, what is buffered, what must be dropped
    logic [31:0] mPc, mAddr, mHeldInstr, mInstr, mPc4;
    bit          mReq, mHeld, mDrop, mValid;

    task automatic mReset();
        mPc = 32'h0; mAddr = 32'h0; mHeldInstr = 32'h0; mInstr = 32'h0; mPc4 = 32'h0;
        mReq = 1'b0; mHeld = 1'b0; mDrop = 1'b0; mValid = 1'b0;
    endtask

    task automatic mStep(input bit st, input bit ack, input logic [31:0] rd,
                         input bit rv, input logic [31:0] rp);
        bit got;
        got = ack && mReq;
        if (rv) begin
            mPc = rp & 32'hFFFF_FFFC;
            mValid = 1'b0; mInstr = 32'h0; mHeld = 1'b0;
            mDrop = mReq && !got;
        end else if (mDrop) begin
            if (got) mDrop = 1'b0;
        end else if (mHeld) begin
            if (!st) begin
                mValid = 1'b1; mInstr = mHeldInstr; mPc = mPc + 32'd4; mPc4 = mPc; mHeld = 1'b0;
            end
        end else if (got) begin
            if (!st) begin
                mValid = 1'b1; mInstr = rd; mPc = mPc + 32'd4; mPc4 = mPc;
            end else begin
                mHeld = 1'b1; mHeldInstr = rd;
            end
        end else if (!st) begin
            mValid = 1'b0; mInstr = 32'h0;
        end
        mReq = !mHeld;
        if (!mDrop) mAddr = mPc;
    endtask

    vec_t vecs[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // st ack rdata         rv rpc      | valid instr         pc4       req addr
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,         32'h0,   1, 32'h0));
        vecs.push_back(mk(0, 1, 32'h2008_0005, 0, 32'h0,   1, 32'h2008_0005, 32'h4,   1, 32'h4));
        vecs.push_back(mk(0, 1, 32'h1111_0004, 0, 32'h0,   1, 32'h1111_0004, 32'h8,   1, 32'h8));
        vecs.push_back(mk(1, 1, 32'h2222_0008, 0, 32'h0,   1, 32'h1111_0004, 32'h8,   0, 32'h8));
        vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,   1, 32'h1111_0004, 32'h8,   0, 32'h8));
        vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,   1, 32'h1111_0004, 32'h8,   0, 32'h8));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,   1, 32'h2222_0008, 32'hC,   1, 32'hC));
        vecs.push_back(mk(0, 1, 32'h3333_000C, 0, 32'h0,   1, 32'h3333_000C, 32'h10,  1, 32'h10));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,         32'h0,   1, 32'h10));
        vecs.push_back(mk(0, 0, 32'h0,         1, 32'h40,  0, 32'h0,         32'h0,   1, 32'h10));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,         32'h0,   1, 32'h10));
        vecs.push_back(mk(0, 1, 32'hDEAD_BEEF, 0, 32'h0,   0, 32'h0,         32'h0,   1, 32'h40));
        vecs.push_back(mk(0, 1, 32'h4444_0040, 0, 32'h0,   1, 32'h4444_0040, 32'h44,  1, 32'h44));
        vecs.push_back(mk(1, 1, 32'h5555_0044, 1, 32'h81,  0, 32'h0,         32'h0,   1, 32'h80));
        vecs.push_back(mk(0, 1, 32'h6666_0080, 0, 32'h0,   1, 32'h6666_0080, 32'h84,  1, 32'h84));
        vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,   1, 32'h6666_0080, 32'h84,  1, 32'h84));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,   0, 32'h0,         32'h0,   1, 32'h84));
        vecs.push_back(mk(1, 1, 32'h7777_0084, 0, 32'h0,   0, 32'h0,         32'h0,   0, 32'h84));
        vecs.push_back(mk(1, 0, 32'h0,         1, 32'h100, 0, 32'h0,         32'h0,   1, 32'h100));
        vecs.push_back(mk(0, 1, 32'h8888_0100, 0, 32'h0,   1, 32'h8888_0100, 32'h104, 1, 32'h104));
        vecs.push_back(mk(0, 0, 32'h0,         1, 32'h200, 0, 32'h0,         32'h0,   1, 32'h104));
        vecs.push_back(mk(0, 0, 32'h0,         1, 32'h303, 0, 32'h0,         32'h0,   1, 32'h104));
        vecs.push_back(mk(0, 1, 32'hBAD0_0104, 0, 32'h0,   0, 32'h0,         32'h0,   1, 32'h300));
        vecs.push_back(mk(0, 1, 32'h9999_0300, 0, 32'h0,   1, 32'h9999_0300, 32'h304, 1, 32'h304));

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4",   if_id_pc4,   32'h0);
        chk("rst_req",   {31'h0, imem_req}, 32'h0);
        chk("rst_addr",  imem_addr,   32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].st; imem_ack = vecs[i].ack; imem_rdata = vecs[i].rd;
            redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rp;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'h0, if_id_valid}, {31'h0, vecs[i].ev});
            chk($sformatf("v%0d_instr", i), if_id_instr, vecs[i].ei);
            if (vecs[i].ev) chk($sformatf("v%0d_pc4", i), if_id_pc4, vecs[i].ep);
            chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].er});
            chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].ea);
            if (i == 0) chk("hiReset_addr0", imem_addr2, 32'hFFFF_FFFC);
            if (i == 1) begin
                chk("hiReset_valid", {31'h0, if_id_valid2}, 32'h1);
                chk("hiReset_pc4",   if_id_pc42, 32'h0);
                chk("hiReset_addr1", imem_addr2, 32'h0);
            end
            @(negedge clk);
        end

        // Reset asserted while a dropped request is outstanding
        stall = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h500;
        @(posedge clk);
        #1;
        chk("drop_addr", imem_addr, 32'h304);
        chk("drop_req",  {31'h0, imem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", {31'h0, if_id_valid}, 32'h0);
        chk("async_instr", if_id_instr, 32'h0);
        chk("async_req",   {31'h0, imem_req}, 32'h0);
        chk("async_addr",  imem_addr, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_req",  {31'h0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr, 32'h0);
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'hABCD_0000;
        @(posedge clk);
        #1;
        chk("rel_valid", {31'h0, if_id_valid}, 32'h1);
        chk("rel_instr", if_id_instr, 32'hABCD_0000);
        chk("rel_pc4",   if_id_pc4, 32'h4);
        chk("rel_addr2", imem_addr, 32'h4);

        // Randomized run against the model
        @(negedge clk);
        imem_ack = 1'b0;
        rst_n = 1'b0;
        mReset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            imem_ack       = mReq && ($urandom_range(0, 2) != 0);
            imem_rdata     = $urandom;
            @(posedge clk);
            mStep(stall, imem_ack, imem_rdata, redirect_valid, redirect_pc);
            #1;
            chk("rnd_valid", {31'h0, if_id_valid}, {31'h0, mValid});
            chk("rnd_instr", if_id_instr, mInstr);
            if (mValid) chk("rnd_pc4", if_id_pc4, mPc4);
            chk("rnd_opcode", {26'h0, if_id_opcode}, {26'h0, mInstr[31:26]});
            chk("rnd_funct",  {26'h0, if_id_funct},  {26'h0, mInstr[5:0]});
            chk("rnd_req",  {31'h0, imem_req}, {31'h0, mReq});
            chk("rnd_addr", imem_addr, mAddr);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
